ptr_sequencer: RTL
==================

PTR_SEQUENCER -- requirements
Module: ptr_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, motor spin-up cycles before sprocket holes are accepted.
REQ-002 SHALL have parameter STOP_CHAR, default 5'b10000, tape stop code.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, cycles without a sprocket hole before run-out.
REQ-004 SHALL have port `CLOCK`, input, 1 bit: single system clock.
REQ-005 SHALL have port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port `FWD_REQ`, input, 1 bit: forward read request (driven by PHOTO_TAPE_FWD).
REQ-007 SHALL have port `REV_REQ`, input, 1 bit: reverse-to-stop-code request.
REQ-008 SHALL have port `SPROCKET`, input, 1 bit: asynchronous sprocket-hole sensor.
REQ-009 SHALL have port `HOLES`, input, 5 bits: asynchronous data-channel sensors.
REQ-010 SHALL have port `CHAR_ACK`, input, 1 bit: consumer accepted CHAR.
REQ-011 SHALL have port `MOTOR_ON`, output, 1 bit: reader motor enable.
REQ-012 SHALL have port `MOTOR_REV`, output, 1 bit: motor direction, 1 = reverse.
REQ-013 SHALL have port `CHAR`, output, 5 bits: captured character.
REQ-014 SHALL have port `CHAR_RDY`, output, 1 bit: CHAR valid.
REQ-015 SHALL have port `STOP_CODE`, output, 1 bit: one-cycle pulse when a stop code is read.
REQ-016 SHALL have port `OVERRUN`, output, 1 bit: sticky, a character was lost.
REQ-017 SHALL have port `RUNOUT`, output, 1 bit: sticky, tape run-out timeout.
REQ-018 SHALL have port `BUSY`, output, 1 bit: state is not IDLE.

Function
REQ-019 SHALL pass SPROCKET and HOLES through 2-flop synchronizers; a sprocket event is a 0->1 edge of synchronized SPROCKET, and HOLES is sampled from the synchronized copy in the same cycle.
REQ-020 SHALL implement states IDLE, SPINUP, RUN, WAIT_ACK.
REQ-021 In IDLE, if FWD_REQ=1 it SHALL go to SPINUP with dir=fwd; else if REV_REQ=1 it SHALL go to SPINUP with dir=rev; if both are 1, forward SHALL win; MOTOR_ON and BUSY SHALL be 1 from the following cycle.
REQ-022 On IDLE exit, OVERRUN and RUNOUT SHALL clear.
REQ-023 MOTOR_REV SHALL equal dir whenever MOTOR_ON=1, and SHALL be 0 otherwise.
REQ-024 SPINUP SHALL count SETTLE_CYCLES cycles, ignoring sprocket events, then enter RUN.
REQ-025 In RUN, on a sprocket event CHAR SHALL load HOLES.
REQ-026 In RUN, if the loaded value equals STOP_CHAR: STOP_CODE SHALL pulse for 1 cycle, MOTOR_ON SHALL drop, and the state SHALL go to IDLE; this applies in both directions.
REQ-027 In RUN with dir=fwd and a non-stop character, CHAR_RDY SHALL be 1 in the next cycle and the state SHALL go to WAIT_ACK.
REQ-028 In RUN with dir=rev, non-stop characters SHALL be discarded (CHAR_RDY stays 0).
REQ-029 In WAIT_ACK, CHAR SHALL be held stable with CHAR_RDY=1; CHAR_ACK=1 SHALL clear CHAR_RDY in the next cycle and return to RUN.
REQ-030 A sprocket event in WAIT_ACK SHALL set OVERRUN and be discarded; CHAR SHALL be unchanged.
REQ-031 A sprocket event coincident with CHAR_ACK SHALL be treated as a RUN event (captured, no overrun).
REQ-032 Deassertion of the request for the active direction in any non-IDLE state SHALL go to IDLE next cycle, with MOTOR_ON=0 and CHAR_RDY=0.
REQ-033 The opposite-direction request SHALL be ignored while not in IDLE.
REQ-034 CHAR_ACK SHALL be ignored while CHAR_RDY=0.

Reset
REQ-035 rst=1 SHALL force, on the next CLOCK edge: state IDLE, dir=fwd, all counters 0, synchronizers 0, MOTOR_ON=0, MOTOR_REV=0, CHAR=0, CHAR_RDY=0, STOP_CODE=0, OVERRUN=0, RUNOUT=0, BUSY=0.
REQ-036 rst SHALL take precedence over every other input, including mid-operation.

Configuration
REQ-037 With G15_PTR_TIMEOUT_EN defined: in RUN and WAIT_ACK, a counter reset by each sprocket event and on RUN entry SHALL, on reaching TIMEOUT_CYCLES, set RUNOUT, drop MOTOR_ON and CHAR_RDY, and go to IDLE.
REQ-038 Without G15_PTR_TIMEOUT_EN: no timeout counter SHALL exist, RUNOUT SHALL be tied 0, and the port list SHALL be unchanged.

Verification
REQ-039 FWD_REQ=1, SETTLE_CYCLES=16, sprocket edges with HOLES=5'h03 then 5'h10 -> MOTOR_ON=1 after 1 cycle; CHAR=03 with CHAR_RDY=1; after ACK, STOP_CODE pulses once; MOTOR_ON=0; BUSY=0.
REQ-040 REV_REQ=1, HOLES sequence 05, 0A, 10 -> MOTOR_REV=1; CHAR_RDY never 1; STOP_CODE pulse on 10; then IDLE.
REQ-041 FWD run, CHAR=07 pending, no ACK, second edge with 09 -> OVERRUN=1; CHAR stays 07; ACK clears CHAR_RDY.
REQ-042 FWD_REQ and REV_REQ both 1 in IDLE -> MOTOR_REV=0; dropping FWD_REQ mid-RUN -> MOTOR_ON=0 next cycle.
REQ-043 With G15_PTR_TIMEOUT_EN and TIMEOUT_CYCLES=64, no sprocket after SPINUP -> RUNOUT=1 at 64 cycles, IDLE; without the macro -> RUNOUT stays 0 and motor stays on.
REQ-044 rst=1 asserted in WAIT_ACK -> all outputs 0 next cycle; with FWD_REQ held, a fresh SPINUP starts after rst falls.

Source files
------------

// File: rtl/ptr_sequencer.sv
// Photo-tape reader sequencer: motor spin-up, sprocket-timed character capture and consumer handshake.
// Define G15_PTR_TIMEOUT_EN to enable the sprocket run-out timeout (RUNOUT is tied 0 otherwise).
module ptr_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [4:0]  STOP_CHAR      = 5'b10000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       FWD_REQ,
  input  logic       REV_REQ,
  input  logic       SPROCKET,
  input  logic [4:0] HOLES,
  input  logic       CHAR_ACK,
  output logic       MOTOR_ON,
  output logic       MOTOR_REV,
  output logic [4:0] CHAR,
  output logic       CHAR_RDY,
  output logic       STOP_CODE,
  output logic       OVERRUN,
  output logic       RUNOUT,
  output logic       BUSY
);

  // One counter serves spin-up (SPINUP) and run-out timing (RUN/WAIT_ACK); the states never overlap.
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef G15_PTR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPINUP,
    ST_RUN,
    ST_WAIT_ACK
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       char_q, char_d;
  logic             char_rdy_q, char_rdy_d;
  logic             stop_code_q, stop_code_d;
  logic             overrun_q, overrun_d;
  logic             motor_on_q, motor_on_d;
  logic             motor_rev_q, motor_rev_d;
  logic             busy_q, busy_d;
  logic [2:0]       spr_sync_q, spr_sync_d;
  logic [4:0]       holes_s1_q, holes_s1_d;
  logic [4:0]       holes_s2_q, holes_s2_d;
`ifdef G15_PTR_TIMEOUT_EN
  logic             runout_q, runout_d;
`endif

  logic spr_evt;
  logic req_act;
  logic take_evt;

  // spr_sync_q[1] is the synchronized sensor, spr_sync_q[2] its previous value for edge detection.
  assign spr_evt = spr_sync_q[1] & ~spr_sync_q[2];
  assign req_act = dir_q ? REV_REQ : FWD_REQ;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    char_d      = char_q;
    char_rdy_d  = char_rdy_q;
    stop_code_d = 1'b0;
    overrun_d   = overrun_q;
    motor_on_d  = motor_on_q;
    take_evt    = 1'b0;
`ifdef G15_PTR_TIMEOUT_EN
    runout_d    = runout_q;
`endif
    spr_sync_d  = {spr_sync_q[1:0], SPROCKET};
    holes_s1_d  = HOLES;
    holes_s2_d  = holes_s1_q;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (FWD_REQ || REV_REQ) begin
        state_d    = ST_SPINUP;
        dir_d      = ~FWD_REQ;
        motor_on_d = 1'b1;
        overrun_d  = 1'b0;
`ifdef G15_PTR_TIMEOUT_EN
        runout_d   = 1'b0;
`endif
      end
    end else if (!req_act) begin
      state_d    = ST_IDLE;
      motor_on_d = 1'b0;
      char_rdy_d = 1'b0;
      cnt_d      = '0;
    end else if (state_q == ST_SPINUP) begin
      if (cnt_q == SPIN_LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // RUN or WAIT_ACK; an event coincident with the ack is handled as a RUN capture.
      take_evt = spr_evt && ((state_q == ST_RUN) || CHAR_ACK);
      if ((state_q == ST_WAIT_ACK) && CHAR_ACK) begin
        char_rdy_d = 1'b0;
        state_d    = ST_RUN;
      end
      if (spr_evt && !take_evt) begin
        overrun_d = 1'b1;
      end
      if (take_evt) begin
        char_d = holes_s2_q;
        if (holes_s2_q == STOP_CHAR) begin
          stop_code_d = 1'b1;
          motor_on_d  = 1'b0;
          char_rdy_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (!dir_q) begin
          char_rdy_d = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
`ifdef G15_PTR_TIMEOUT_EN
      if (spr_evt) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        runout_d   = 1'b1;
        motor_on_d = 1'b0;
        char_rdy_d = 1'b0;
        state_d    = ST_IDLE;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end

    motor_rev_d = motor_on_d & dir_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      char_q      <= '0;
      char_rdy_q  <= 1'b0;
      stop_code_q <= 1'b0;
      overrun_q   <= 1'b0;
      motor_on_q  <= 1'b0;
      motor_rev_q <= 1'b0;
      busy_q      <= 1'b0;
      spr_sync_q  <= '0;
      holes_s1_q  <= '0;
      holes_s2_q  <= '0;
`ifdef G15_PTR_TIMEOUT_EN
      runout_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      char_rdy_q  <= char_rdy_d;
      stop_code_q <= stop_code_d;
      overrun_q   <= overrun_d;
      motor_on_q  <= motor_on_d;
      motor_rev_q <= motor_rev_d;
      busy_q      <= busy_d;
      spr_sync_q  <= spr_sync_d;
      holes_s1_q  <= holes_s1_d;
      holes_s2_q  <= holes_s2_d;
`ifdef G15_PTR_TIMEOUT_EN
      runout_q    <= runout_d;
`endif
    end
  end

  assign MOTOR_ON  = motor_on_q;
  assign MOTOR_REV = motor_rev_q;
  assign CHAR      = char_q;
  assign CHAR_RDY  = char_rdy_q;
  assign STOP_CODE = stop_code_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = busy_q;
`ifdef G15_PTR_TIMEOUT_EN
  assign RUNOUT    = runout_q;
`else
  assign RUNOUT    = 1'b0;
`endif

endmodule
